// File: rtl/usb_frame_tx_pkg.sv
// rtl/usb_frame_tx_pkg.sv - shared types and defaults for the FT2232H frame transmitter
package usb_frame_tx_pkg;

    localparam int         USB_DATA_WIDTH = 8;
    localparam logic [7:0] DEF_START_FLAG = 8'h5A;
    localparam logic [7:0] DEF_STOP_FLAG  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SEQ   = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    function automatic int bytes_per_sample(input int sample_width);
        return (sample_width + 7) / 8;
    endfunction

endpackage

// File: rtl/usb_frame_tx_serializer.sv
// rtl/usb_frame_tx_serializer.sv - holds one sample and walks enabled channels, LSB byte first
module usb_frame_tx_serializer
    import usb_frame_tx_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic [CHANNELS-1:0]              mask,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] s_data,
    input  logic                             load,
    input  logic                             advance,
    output logic                             valid,
    output logic                             last,
    output logic [USB_DATA_WIDTH-1:0]        byte_o
);

    localparam int   CW     = $clog2(CHANNELS + 1);
    localparam int   NBYTES = bytes_per_sample(SAMPLE_WIDTH);
    localparam logic LAST_B = (NBYTES == 2);

    // Lowest enabled channel at or above 'from'; CHANNELS means none left.
    function automatic logic [CW-1:0] first_en(input logic [CHANNELS-1:0] m, input int from);
        logic [CW-1:0] r;
        r = CW'(CHANNELS);
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = CW'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] pick(input logic [CHANNELS*SAMPLE_WIDTH-1:0] d,
                                        input logic [CW-1:0] ch, input logic b);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CW'(i) == ch) w[SAMPLE_WIDTH-1:0] = d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
        return b ? w[15:8] : w[7:0];
    endfunction

    logic [CHANNELS*SAMPLE_WIDTH-1:0] hold_q;
    logic [CW-1:0]                    chan_q;
    logic                             bidx_q;
    logic                             valid_q;
    logic [7:0]                       byte_q;

    logic [CW-1:0] next_chan;
    logic [CW-1:0] first_chan;
    logic          at_last_byte;

    assign next_chan    = first_en(mask, int'(chan_q) + 1);
    assign first_chan   = first_en(mask, 0);
    assign at_last_byte = (bidx_q == LAST_B);

    assign valid  = valid_q;
    assign last   = at_last_byte && (next_chan == CW'(CHANNELS));
    assign byte_o = byte_q;

    // Load wins over advance so the next sample follows the last byte with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            chan_q  <= '0;
            bidx_q  <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            hold_q  <= s_data;
            chan_q  <= first_chan;
            bidx_q  <= 1'b0;
            byte_q  <= pick(s_data, first_chan, 1'b0);
            valid_q <= 1'b1;
        end else if (advance && valid_q) begin
            if (last) begin
                valid_q <= 1'b0;
            end else if (!at_last_byte) begin
                bidx_q <= 1'b1;
                byte_q <= pick(hold_q, chan_q, 1'b1);
            end else begin
                chan_q <= next_chan;
                bidx_q <= 1'b0;
                byte_q <= pick(hold_q, next_chan, 1'b0);
            end
        end
    end

endmodule

// File: rtl/usb_frame_tx.sv
// rtl/usb_frame_tx.sv - frames multi-channel samples onto the FT2232H sync-FIFO write port
module usb_frame_tx
    import usb_frame_tx_pkg::*;
#(
    parameter int         CHANNELS     = 2,
    parameter int         SAMPLE_WIDTH = 12,
    parameter int         FRAME_LEN    = 20480,
    parameter int         SEQ_EN       = 1,
    parameter logic [7:0] START_FLAG   = DEF_START_FLAG,
    parameter logic [7:0] STOP_FLAG    = DEF_STOP_FLAG
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             abort,
    input  logic [CHANNELS-1:0]              chan_en,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             ft_txe_n_i,
    output logic                             ft_wr_n_o,
    output logic [USB_DATA_WIDTH-1:0]        ft_data_o,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int               CTR_W = $clog2(FRAME_LEN + 1);
    localparam logic [CTR_W-1:0] LEN   = CTR_W'(FRAME_LEN);

    state_t              state_q, state_n;
    logic [7:0]          ctl_byte_q;
    logic                ctl_pending_q;
    logic [7:0]          seq_q;
    logic [CTR_W-1:0]    sample_ctr_q;
    logic [CHANNELS-1:0] mask_q;

    logic       in_data;
    logic       byte_pending;
    logic       accept;
    logic       ser_valid;
    logic       ser_last;
    logic [7:0] ser_byte;
    logic       ser_load;
    logic       ser_clear;

    assign in_data      = (state_q == ST_DATA);
    assign byte_pending = in_data ? ser_valid : ctl_pending_q;
    assign accept       = byte_pending && !ft_txe_n_i;

    assign ft_wr_n_o  = ~accept;
    assign ft_data_o  = in_data ? ser_byte : ctl_byte_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_STOP) && accept;

    assign s_ready   = in_data && !abort && (sample_ctr_q < LEN)
                       && (!ser_valid || (accept && ser_last));
    assign ser_load  = s_valid && s_ready;
    assign ser_clear = in_data && abort;

    usb_frame_tx_serializer #(
        .CHANNELS     (CHANNELS),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .clear   (ser_clear),
        .mask    (mask_q),
        .s_data  (s_data),
        .load    (ser_load),
        .advance (accept && in_data),
        .valid   (ser_valid),
        .last    (ser_last),
        .byte_o  (ser_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_n = ST_START;
            end
            ST_START: begin
                if (abort)       state_n = ST_STOP;
                else if (accept) state_n = (SEQ_EN != 0) ? ST_SEQ
                                         : ((mask_q == '0) ? ST_STOP : ST_DATA);
            end
            ST_SEQ: begin
                if (abort)       state_n = ST_STOP;
                else if (accept) state_n = (mask_q == '0) ? ST_STOP : ST_DATA;
            end
            ST_DATA: begin
                if (abort) state_n = ST_STOP;
                else if (accept && ser_last && sample_ctr_q == LEN) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (accept) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Control bytes (START/SEQ/STOP) are loaded on state entry, which also
    // replaces a stalled data byte with STOP_FLAG on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_byte_q    <= '0;
            ctl_pending_q <= 1'b0;
            seq_q         <= '0;
            sample_ctr_q  <= '0;
            mask_q        <= '0;
        end else begin
            if (state_q == ST_IDLE && state_n == ST_START) begin
                mask_q       <= chan_en;
                sample_ctr_q <= '0;
            end
            if (ser_load) sample_ctr_q <= sample_ctr_q + CTR_W'(1);
            if (frame_done) seq_q <= seq_q + 8'd1;
            if (state_n != state_q) begin
                case (state_n)
                    ST_START: begin
                        ctl_byte_q    <= START_FLAG;
                        ctl_pending_q <= 1'b1;
                    end
                    ST_SEQ: begin
                        ctl_byte_q    <= seq_q;
                        ctl_pending_q <= 1'b1;
                    end
                    ST_STOP: begin
                        ctl_byte_q    <= STOP_FLAG;
                        ctl_pending_q <= 1'b1;
                    end
                    default: ctl_pending_q <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_frame_tx.sv
// tb/tb_usb_frame_tx.sv - scoreboard bench for usb_frame_tx (2 channels, 12-bit, 4 samples/frame)
module tb_usb_frame_tx;

    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst, enable, abort, s_valid, s_ready;
    logic        ft_txe_n_i, ft_wr_n_o, busy, frame_done;
    logic [1:0]  chan_en;
    logic [23:0] s_data;
    logic [7:0]  ft_data_o;

    always #5 clk = ~clk;

    usb_frame_tx #(
        .CHANNELS     (2),
        .SAMPLE_WIDTH (12),
        .FRAME_LEN    (FL),
        .SEQ_EN       (1),
        .START_FLAG   (8'h5A),
        .STOP_FLAG    (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .abort      (abort),
        .chan_en    (chan_en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ft_txe_n_i (ft_txe_n_i),
        .ft_wr_n_o  (ft_wr_n_o),
        .ft_data_o  (ft_data_o),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         acc_cnt = 0;
    int         done_cnt = 0;
    int         sready_hi = 0;
    int         gap = 0;
    bit         gap_chk = 0;
    bit         after_stop = 0;
    bit         txe_rand = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_seq = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL timeout_%s actual=expired required=event", name);
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        exp_t e;
        e.b    = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // s_data = {12'hABC, 12'h123}: ch0 -> 23,01  ch1 -> BC,0A
    task automatic push_frame(input logic [1:0] m);
        push(8'h5A, 1'b0);
        push(exp_seq, 1'b0);
        for (int s = 0; s < FL; s++) begin
            if (m[0]) begin push(8'h23, 1'b0); push(8'h01, 1'b0); end
            if (m[1]) begin push(8'hBC, 1'b0); push(8'h0A, 1'b0); end
        end
        push(8'hA5, 1'b1);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n = 0;
        while (busy !== lvl && n < 4000) begin @(posedge clk); #1; n++; end
        if (n >= 4000) timeout(name);
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_cnt < target && n < 4000) begin @(posedge clk); #1; n++; end
        if (n >= 4000) timeout(name);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 4000) begin @(posedge clk); #1; n++; end
        if (n >= 4000) timeout(name);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin @(posedge clk); #1; n++; end
        if (n >= 4000) timeout(name);
    endtask

    task automatic run_frame(input logic [1:0] m, input string name);
        chan_en = m;
        push_frame(m);
        enable = 1'b1;
        wait_busy(1'b1, {name, "_start"});
        enable = 1'b0;
        wait_busy(1'b0, {name, "_end"});
        wait_drain({name, "_drain"});
    endtask

    initial begin
        ft_txe_n_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ft_txe_n_i = txe_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: every write strobe pops one expected byte; stalls must hold data.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (s_ready) sready_hi++;
            if (prev_stall) check("stall_stable", ft_data_o, prev_data);
            if (ft_wr_n_o === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h required=none", ft_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", ft_data_o, e.b);
                    check("frame_done", frame_done, e.last);
                end
                if (gap_chk && after_stop) check("idle_gap", gap, 1);
                after_stop = (frame_done === 1'b1);
                gap = 0;
                acc_cnt++;
                if (frame_done === 1'b1) done_cnt++;
            end else begin
                gap++;
            end
            prev_stall = txe_rand && busy && ft_txe_n_i && exp_q.size() > 0
                         && ft_data_o == exp_q[0].b;
            prev_data  = ft_data_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int snap;
        rst = 1'b1; enable = 1'b0; abort = 1'b0; s_valid = 1'b1;
        s_data = {12'hABC, 12'h123}; chan_en = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_n", ft_wr_n_o, 1'b1);
        check("rst_data", ft_data_o, 8'h00);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(2'b11, "basic");

        txe_rand = 1'b1;
        run_frame(2'b11, "stall");
        txe_rand = 1'b0;
        @(posedge clk); #1;

        run_frame(2'b10, "mask10");

        snap = sready_hi;
        run_frame(2'b00, "mask00");
        check("sready_mask00", sready_hi - snap, 0);

        chan_en = 2'b11;
        push(8'h5A, 1'b0); push(exp_seq, 1'b0);
        push(8'h23, 1'b0); push(8'h01, 1'b0); push(8'hBC, 1'b0);
        push(8'hA5, 1'b1);
        exp_seq = exp_seq + 8'd1;
        base = acc_cnt;
        enable = 1'b1;
        wait_busy(1'b1, "abort_start");
        enable = 1'b0;
        begin
            int n = 0;
            while (!(acc_cnt == base + 4 && ft_wr_n_o == 1'b0) && n < 200) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 200) timeout("abort_point");
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_busy(1'b0, "abort_end");
        wait_drain("abort_drain");

        run_frame(2'b11, "post_abort");

        chan_en = 2'b00;
        for (int k = 0; k < 257; k++) begin
            push(8'h5A, 1'b0); push(exp_seq, 1'b0); push(8'hA5, 1'b1);
            exp_seq = exp_seq + 8'd1;
        end
        base = done_cnt;
        enable = 1'b1;
        wait_done(base + 1, "wrap_first");
        gap_chk = 1'b1;
        wait_done(base + 256, "wrap_256");
        wait_busy(1'b1, "wrap_last_start");
        enable = 1'b0;
        wait_busy(1'b0, "wrap_end");
        gap_chk = 1'b0;
        wait_drain("wrap_drain");
        check("wrap_frames", done_cnt - base, 257);

        s_valid = 1'b0;
        chan_en = 2'b11;
        push(8'h5A, 1'b0); push(exp_seq, 1'b0);
        push(8'h23, 1'b0); push(8'h01, 1'b0); push(8'hBC, 1'b0); push(8'h0A, 1'b0);
        base = acc_cnt;
        enable = 1'b1;
        wait_busy(1'b1, "gap_start");
        enable = 1'b0;
        wait_acc(base + 2, "gap_hdr");
        s_valid = 1'b1;
        check("gap_s_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_acc(base + 6, "gap_sample");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("gap_wr_n", ft_wr_n_o, 1'b1);
            check("gap_busy", busy, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_wr_n", ft_wr_n_o, 1'b1);
        check("mid_rst_data", ft_data_o, 8'h00);
        check("mid_rst_s_ready", s_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        check("mid_rst_queue", exp_q.size(), 0);
        rst = 1'b0;
        s_valid = 1'b1;
        exp_seq = 8'h00;
        @(posedge clk); #1;
        run_frame(2'b11, "after_rst");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
